cache_trace_driver: RTL and testbench
=====================================

Name: cache_trace_driver

Overview:
- Parametrised, programmable replacement for the fixed-list cache request stub.
- Holds a loadable trace of up to DEPTH read/write operations and replays it to the cache under test, one request at a time, advancing on `hit`.
- Adds start/re-run control, a per-request timeout, stall-cycle statistics, and optional read-data checking.
- Sits between the testbench and the cache, in place of the CPU stub.

Parameters:
ADDR_W, 8, request address width (matches MEM_ADDR_SIZE)
DATA_W, 32, data width (matches WORD_SIZE_BIT)
DEPTH, 16, maximum trace entries; any value >= 1
TIMEOUT, 64, max cycles a single request may wait for hit; 0 disables timeout
STAT_W, 16, width of statistics counters

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low reset
prog_we  in  1  write one trace entry (accepted only when busy=0)
prog_idx  in  $clog2(DEPTH)  entry index to write
prog_rd  in  1  1=read op, 0=write op
prog_addr  in  ADDR_W  entry address
prog_data  in  DATA_W  write data (write op) / expected data (read op)
num_ops  in  $clog2(DEPTH+1)  entries to replay, sampled on start
start  in  1  one-cycle pulse, begin replay from entry 0
rData  in  DATA_W  cache read data, valid with hit on a read
hit  in  1  cache completed current request this cycle
Address  out  ADDR_W  current request address
Write_Data  out  DATA_W  current write data
read  out  1  read request
write  out  1  write request
busy  out  1  replay in progress
finish  out  1  replay complete, held until next start or reset
timeout  out  1  replay aborted by timeout, held like finish
stall_cycles  out  STAT_W  cycles in ISSUE with hit=0, saturating
done_ops  out  STAT_W  requests completed in the last or current run

Behaviour:
- FSM states: IDLE, ISSUE, DONE.
- Reset (reset=0 at posedge):
  - State goes to IDLE.
  - read, write, busy, finish, timeout, stall_cycles, done_ops all 0; index 0; wait counter 0.
  - Trace storage is not cleared.
  - Reset mid-replay aborts immediately. No request is asserted in the following cycle.
- IDLE:
  - Outputs read=write=0. Address and Write_Data are don't-care (drive 0).
  - prog_we writes entry[prog_idx]. prog_idx >= DEPTH is ignored.
  - start with num_ops=0 goes to DONE directly (finish=1, done_ops=0).
  - start with num_ops>DEPTH is clamped to DEPTH.
  - Otherwise start latches num_ops, clears stats and timeout, and goes to ISSUE with index 0.
- ISSUE:
  - busy=1. Address, Write_Data, read and write are driven combinationally from entry[index].
  - Exactly one of read/write is 1.
  - Request is held stable until hit=1 is sampled.
  - On hit: done_ops+1, wait counter cleared.
    - If index==num_ops-1, go to DONE.
    - Otherwise index+1, and the next request is presented the following cycle (zero bubble).
  - hit=0: stall_cycles+1 (saturates at all-ones), wait counter +1.
  - If TIMEOUT>0 and the wait counter reaches TIMEOUT-1 while hit=0, go to DONE with timeout=1.
- DONE:
  - finish=1, busy=0, read=write=0.
  - Stats held. start re-runs as from IDLE.
  - prog_we is accepted.
- Ignored inputs:
  - hit outside ISSUE.
  - start and prog_we while busy.
- Simultaneous events:
  - hit and timeout in the same cycle: hit wins.
  - start in the same cycle as the final hit: ignored.

Optional Feature:
- Macro: CACHE_TRACE_DRIVER_CHECK_EN.
- When defined:
  - Adds output mismatch_cnt (STAT_W) and output mismatch (1).
  - On each hit for a read op, rData is compared with the stored prog_data. On mismatch, mismatch_cnt increments (saturating) and mismatch is pulsed high for 1 cycle.
  - Both outputs clear on reset and on an accepted start.
- When undefined: these ports and the comparator are absent; the read op's prog_data is unused.

Decomposition:
- Shared package:
  - State enum {IDLE, ISSUE, DONE}.
  - Trace entry struct {rd, addr[ADDR_W], data[DATA_W]}.
  - Default width constants tied to MEM_ADDR_SIZE and WORD_SIZE_BIT.
- One sub-module: trace_store. It is a DEPTH-entry register file with 1 write port and 1 asynchronous read port, no reset.

Test Plan:
- Program 10 entries (alternating rd/wr; addr 0x24, 0xA4, …; data 588, 716, …), num_ops=10, hit tied 1 -> one request per cycle, in order; finish asserts on the cycle after the 10th hit; done_ops=10; stall_cycles=0.
- Same trace, hit asserted every 3rd cycle -> each request held stable for 3 cycles; stall_cycles=20; finish after 30 cycles.
- TIMEOUT=8, hit never asserted -> entry 0 held for 8 cycles, then timeout=1, finish=1, done_ops=0, read/write=0.
- start with num_ops=0 -> finish next cycle, no read/write ever asserted; start with num_ops=20 on DEPTH=16 -> exactly 16 requests.
- reset=0 pulsed during entry 4 -> next cycle all outputs 0, state IDLE; new start replays from entry 0 with the trace intact.
- CHECK_EN: read entry expects 0x1234, cache returns 0x1235 on hit -> mismatch pulses 1 cycle, mismatch_cnt=1; matching reads leave it unchanged.

Source files
------------

// File: rtl/cache_trace_driver_pkg.sv
// Shared types and default widths for the cache trace driver and its trace store.
// The optional read-data checker is enabled by defining CACHE_TRACE_DRIVER_CHECK_EN.
package cache_trace_driver_pkg;

    // Default widths match the memory system the driver is attached to.
    localparam int MEM_ADDR_SIZE = 8;
    localparam int WORD_SIZE_BIT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Layout of one trace entry at the default widths; the top rebuilds the
    // same layout from its own parameters so other widths work too.
    typedef struct packed {
        logic                     rd;
        logic [MEM_ADDR_SIZE-1:0] addr;
        logic [WORD_SIZE_BIT-1:0] data;
    } trace_entry_t;

    // Index width that stays at least one bit wide for a single-entry trace.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cache_trace_driver_trace_store.sv
// Trace storage: DEPTH-entry register file, one write port, one asynchronous
// read port. Deliberately not reset so a programmed trace survives a reset.
module cache_trace_driver_trace_store #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 41,
    parameter int IDX_W = 4
) (
    input  logic             clock,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Single write port; the caller already filtered out-of-range indices.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/cache_trace_driver.sv
// Cache trace driver: replays a programmable list of read/write requests to a
// cache, one at a time, advancing on hit, with per-request timeout and stats.
// Define CACHE_TRACE_DRIVER_CHECK_EN to add read-data checking (mismatch ports).
module cache_trace_driver
    import cache_trace_driver_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_SIZE,
    parameter int DATA_W  = WORD_SIZE_BIT,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64,
    parameter int STAT_W  = 16,
    localparam int IDX_W  = idx_width(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [IDX_W-1:0]  prog_idx,
    input  logic              prog_rd,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic [CNT_W-1:0]  num_ops,
    input  logic              start,
    input  logic [DATA_W-1:0] rData,
    input  logic              hit,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Write_Data,
    output logic              read,
    output logic              write,
    output logic              busy,
    output logic              finish,
    output logic              timeout,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] done_ops
`ifdef CACHE_TRACE_DRIVER_CHECK_EN
    ,
    output logic [STAT_W-1:0] mismatch_cnt,
    output logic              mismatch
`endif
);

    localparam int WAIT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef struct packed {
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  index;
    logic [CNT_W-1:0]  ops_len;
    logic [WAIT_W-1:0] wait_cnt;
    entry_t            wr_entry;
    entry_t            cur;
    logic              store_we;
    logic              start_ok;
    logic              last_op;
    logic              timeout_now;
    logic [CNT_W-1:0]  num_clamped;

    assign start_ok    = start && (state != ISSUE);
    assign store_we    = prog_we && (state != ISSUE) && (32'(prog_idx) < DEPTH);
    assign last_op     = (CNT_W'(index) + CNT_W'(1)) == ops_len;
    assign timeout_now = (TIMEOUT > 0) && (wait_cnt == WAIT_W'(TO_LAST));
    assign num_clamped = (32'(num_ops) > DEPTH) ? CNT_W'(DEPTH) : num_ops;
    assign wr_entry    = '{rd: prog_rd, addr: prog_addr, data: prog_data};

    cache_trace_driver_trace_store #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t)),
        .IDX_W (IDX_W)
    ) u_store (
        .clock   (clock),
        .we      (store_we),
        .wr_idx  (prog_idx),
        .wr_data (wr_entry),
        .rd_idx  (index),
        .rd_data (cur)
    );

    // State register; reset aborts any replay immediately.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a final hit beats a timeout in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (num_ops == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (hit) begin
                    if (last_op) begin
                        state_next = DONE;
                    end
                end else if (timeout_now) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request outputs come straight from the current entry while issuing.
    always_comb begin
        busy       = 1'b0;
        finish     = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        Address    = '0;
        Write_Data = '0;
        case (state)
            ISSUE: begin
                busy       = 1'b1;
                read       = cur.rd;
                write      = ~cur.rd;
                Address    = cur.addr;
                Write_Data = cur.data;
            end
            DONE:    finish = 1'b1;
            default: ;
        endcase
    end

    // Replay index, op count, wait counter and run statistics.
    always_ff @(posedge clock) begin
        if (!reset) begin
            index        <= '0;
            ops_len      <= '0;
            wait_cnt     <= '0;
            stall_cycles <= '0;
            done_ops     <= '0;
            timeout      <= 1'b0;
        end else if (start_ok) begin
            index        <= '0;
            ops_len      <= num_clamped;
            wait_cnt     <= '0;
            stall_cycles <= '0;
            done_ops     <= '0;
            timeout      <= 1'b0;
        end else if (state == ISSUE) begin
            if (hit) begin
                wait_cnt <= '0;
                if (done_ops != {STAT_W{1'b1}}) begin
                    done_ops <= done_ops + STAT_W'(1);
                end
                if (!last_op) begin
                    index <= index + IDX_W'(1);
                end
            end else begin
                if (stall_cycles != {STAT_W{1'b1}}) begin
                    stall_cycles <= stall_cycles + STAT_W'(1);
                end
                if (timeout_now) begin
                    timeout <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            end
        end
    end

`ifdef CACHE_TRACE_DRIVER_CHECK_EN
    // Compare returned read data against the stored expectation on each read hit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mismatch_cnt <= '0;
            mismatch     <= 1'b0;
        end else if (start_ok) begin
            mismatch_cnt <= '0;
            mismatch     <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            if ((state == ISSUE) && hit && cur.rd && (rData != cur.data)) begin
                mismatch <= 1'b1;
                if (mismatch_cnt != {STAT_W{1'b1}}) begin
                    mismatch_cnt <= mismatch_cnt + STAT_W'(1);
                end
            end
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^rData;
`endif

endmodule

// File: tb/tb_cache_trace_driver.sv
// Testbench for cache_trace_driver: randomized traces and hit timing, with a
// queue-based reference of the expected request stream and per-run statistics.
module tb_cache_trace_driver;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 8;
    localparam int STAT_W  = 16;

    typedef struct {
        bit          rd;
        logic [7:0]  addr;
        logic [31:0] data;
        int          hold;
    } req_t;

    typedef struct {
        int done;
        int stalls;
        bit to;
    } sum_t;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              prog_we = 1'b0;
    logic [3:0]        prog_idx = '0;
    logic              prog_rd = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [DATA_W-1:0] prog_data = '0;
    logic [4:0]        num_ops = '0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] rData = '0;
    logic              hit = 1'b0;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] Write_Data;
    logic              read;
    logic              write;
    logic              busy;
    logic              finish;
    logic              timeout;
    logic [STAT_W-1:0] stall_cycles;
    logic [STAT_W-1:0] done_ops;
`ifdef CACHE_TRACE_DRIVER_CHECK_EN
    logic [STAT_W-1:0] mismatch_cnt;
    logic              mismatch;
    int                pulse_cnt = 0;
`endif

    cache_trace_driver #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .STAT_W  (STAT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .prog_we      (prog_we),
        .prog_idx     (prog_idx),
        .prog_rd      (prog_rd),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .num_ops      (num_ops),
        .start        (start),
        .rData        (rData),
        .hit          (hit),
        .Address      (Address),
        .Write_Data   (Write_Data),
        .read         (read),
        .write        (write),
        .busy         (busy),
        .finish       (finish),
        .timeout      (timeout),
        .stall_cycles (stall_cycles),
        .done_ops     (done_ops)
`ifdef CACHE_TRACE_DRIVER_CHECK_EN
        ,
        .mismatch_cnt (mismatch_cnt),
        .mismatch     (mismatch)
`endif
    );

    always #5 clock = ~clock;

    // Reference copy of the trace and the per-request hit delays of this run.
    bit          trace_rd   [DEPTH];
    logic [7:0]  trace_addr [DEPTH];
    logic [31:0] trace_data [DEPTH];
    int          stall_plan [DEPTH];

    req_t exp_req[$];
    sum_t exp_sum[$];

    int n_vectors     = 0;
    int n_miscompares = 0;

    bit mon_enable   = 1'b0;
    int resp_k       = 0;
    int resp_wait    = 0;
    bit resp_prev    = 1'b0;
    int corrupt_idx  = -1;

    int   held         = 0;
    bit   mon_prev_req = 1'b0;
    bit   start_seen   = 1'b0;
    bit   req_now;
    req_t mon_e;
    sum_t mon_s;

    task automatic checkOutput(input string name, input longint unsigned actual,
                               input longint unsigned expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Cache model: holds each request for its planned number of stall cycles, then hits.
    always @(negedge clock) begin
        if (resp_prev && hit) begin
            resp_k++;
            resp_wait = 0;
        end else if (resp_prev) begin
            resp_wait++;
        end
        resp_prev = read || write;
        if ((read || write) && (resp_k < DEPTH)) begin
            hit   = (resp_wait >= stall_plan[resp_k]);
            rData = trace_data[resp_k];
            if (resp_k == corrupt_idx) rData = rData ^ 32'h1;
        end else begin
            hit   = 1'($urandom_range(0, 1));
            rData = $urandom;
        end
    end

    // Monitor: every presented request must match the queue front for its full hold time.
    always @(negedge clock) begin
        if (!mon_enable) begin
            held         = 0;
            mon_prev_req = 1'b0;
            start_seen   = 1'b0;
        end else begin
            req_now = read || write;
            if (req_now) begin
                if (exp_req.size() == 0) begin
                    checkOutput("unexpected_request", {Address, 1'b1}, 0);
                end else begin
                    mon_e = exp_req[0];
                    checkOutput("req_read", read, mon_e.rd);
                    checkOutput("req_write", write, !mon_e.rd);
                    checkOutput("req_addr", Address, mon_e.addr);
                    if (!mon_e.rd) checkOutput("req_wdata", Write_Data, mon_e.data);
                    checkOutput("req_busy", busy, 1);
                    held++;
                    if (held >= mon_e.hold) begin
                        void'(exp_req.pop_front());
                        held = 0;
                    end
                end
            end else if (held != 0) begin
                checkOutput("req_hold_cycles", held, exp_req[0].hold);
                void'(exp_req.pop_front());
                held = 0;
            end
            if (finish && (mon_prev_req || start_seen)) begin
                if (exp_sum.size() == 0) begin
                    checkOutput("unexpected_finish", 1, 0);
                end else begin
                    mon_s = exp_sum.pop_front();
                    checkOutput("done_ops", done_ops, mon_s.done);
                    checkOutput("stall_cycles", stall_cycles, mon_s.stalls);
                    checkOutput("timeout", timeout, mon_s.to);
                    checkOutput("finish_busy", busy, 0);
                    checkOutput("finish_rw", {read, write}, 0);
                    checkOutput("finish_reqs_left", exp_req.size(), 0);
                    exp_req.delete();
                end
            end
`ifdef CACHE_TRACE_DRIVER_CHECK_EN
            if (mismatch) pulse_cnt++;
`endif
            mon_prev_req = req_now;
            start_seen   = start && !busy && reset;
        end
    end

    task automatic progEntry(input int idx, input bit rd, input logic [7:0] addr,
                             input logic [31:0] data);
        prog_we   = 1'b1;
        prog_idx  = 4'(idx);
        prog_rd   = rd;
        prog_addr = addr;
        prog_data = data;
        @(posedge clock); #1;
        prog_we = 1'b0;
        trace_rd[idx]   = rd;
        trace_addr[idx] = addr;
        trace_data[idx] = data;
    endtask

    task automatic fillStalls(input int mode);
        int r;
        for (int k = 0; k < DEPTH; k++) begin
            if (mode >= 0) begin
                stall_plan[k] = mode;
            end else begin
                r = $urandom_range(0, 19);
                stall_plan[k] = (r < 17) ? (r % 5) : (r - 10);
            end
        end
    endtask

    // Compute the expected request stream and statistics, then pulse start.
    task automatic startRun(input int n_ops);
        int   n;
        int   stalls;
        int   done;
        bit   to;
        req_t r;
        sum_t s;
        n      = (n_ops > DEPTH) ? DEPTH : n_ops;
        stalls = 0;
        done   = 0;
        to     = 1'b0;
        for (int k = 0; k < n; k++) begin
            r.rd   = trace_rd[k];
            r.addr = trace_addr[k];
            r.data = trace_data[k];
            if (stall_plan[k] >= TIMEOUT) begin
                r.hold = TIMEOUT;
                exp_req.push_back(r);
                stalls += TIMEOUT;
                to = 1'b1;
                break;
            end
            r.hold = stall_plan[k] + 1;
            exp_req.push_back(r);
            stalls += stall_plan[k];
            done++;
        end
        s.done   = done;
        s.stalls = stalls;
        s.to     = to;
        exp_sum.push_back(s);
        resp_k    = 0;
        resp_wait = 0;
        resp_prev = 1'b0;
        num_ops   = 5'(n_ops);
        start     = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Wait for finish, poking ignored start/prog_we pulses while busy.
    task automatic waitFinish();
        int cyc;
        int r;
        cyc = 0;
        while (!finish && cyc < 200) begin
            start   = 1'b0;
            prog_we = 1'b0;
            if (busy) begin
                r = $urandom_range(0, 7);
                if (r == 0) begin
                    start   = 1'b1;
                    num_ops = 5'($urandom_range(0, 20));
                end else if (r == 1) begin
                    prog_we   = 1'b1;
                    prog_idx  = 4'($urandom_range(0, 15));
                    prog_rd   = 1'($urandom_range(0, 1));
                    prog_addr = 8'($urandom);
                    prog_data = $urandom;
                end
            end
            @(posedge clock); #1;
            cyc++;
        end
        start   = 1'b0;
        prog_we = 1'b0;
        if (!finish) checkOutput("finish_wait_budget", cyc, 0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int n_ops);
        startRun(n_ops);
        waitFinish();
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_rw"}, {read, write}, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_finish"}, finish, 0);
        checkOutput({tag, "_timeout"}, timeout, 0);
        checkOutput({tag, "_stall"}, stall_cycles, 0);
        checkOutput({tag, "_done"}, done_ops, 0);
        checkOutput({tag, "_addr"}, Address, 0);
        checkOutput({tag, "_wdata"}, Write_Data, 0);
    endtask

    initial begin
        int cyc;
        fillStalls(0);
        repeat (3) @(posedge clock);
        #1;
        checkIdleOutputs("reset");
        reset      = 1'b1;
        mon_enable = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            if (i < 10) progEntry(i, (i % 2) == 0, 8'(8'h24 + 8'h80 * i), 32'(588 + 128 * i));
            else        progEntry(i, 1'($urandom_range(0, 1)), 8'($urandom), $urandom);
        end

        $display("[TB] back-to-back replay");
        fillStalls(0);
        applyStimulus(10);
        $display("[TB] hit every third cycle");
        fillStalls(2);
        applyStimulus(10);
        $display("[TB] timeout on first entry");
        fillStalls(20);
        applyStimulus(10);
        $display("[TB] zero-length and clamped runs");
        applyStimulus(0);
        fillStalls(-1);
        applyStimulus(20);

        $display("[TB] reset during entry 4");
        for (int i = 0; i < 10; i++) progEntry(i, trace_rd[i], 8'(i * 8 + 3), trace_data[i]);
        fillStalls(1);
        startRun(10);
        cyc = 0;
        while (!((read || write) && Address == trace_addr[4]) && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        if (cyc >= 100) checkOutput("entry4_wait_budget", cyc, 0);
        mon_enable = 1'b0;
        reset      = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        checkIdleOutputs("midreset");
        exp_req.delete();
        exp_sum.delete();
        resp_k     = 0;
        resp_wait  = 0;
        resp_prev  = 1'b0;
        mon_enable = 1'b1;
        @(posedge clock); #1;
        checkOutput("idle_after_reset", {read, write, busy, finish}, 0);
        fillStalls(0);
        applyStimulus(10);

        $display("[TB] random runs");
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int j = 0; j < 3; j++)
                    progEntry($urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 1)), 8'($urandom), $urandom);
            end
            fillStalls(-1);
            applyStimulus($urandom_range(0, 20));
        end

`ifdef CACHE_TRACE_DRIVER_CHECK_EN
        $display("[TB] read-data checking");
        progEntry(0, 1'b1, 8'h10, 32'h1234);
        progEntry(1, 1'b1, 8'h14, 32'h5678);
        progEntry(2, 1'b0, 8'h18, 32'h9abc);
        fillStalls(0);
        corrupt_idx = 0;
        pulse_cnt   = 0;
        applyStimulus(3);
        checkOutput("mismatch_cnt_bad", mismatch_cnt, 1);
        checkOutput("mismatch_pulses", pulse_cnt, 1);
        corrupt_idx = -1;
        pulse_cnt   = 0;
        applyStimulus(3);
        checkOutput("mismatch_cnt_good", mismatch_cnt, 0);
        checkOutput("mismatch_pulses_good", pulse_cnt, 0);
`endif

        repeat (3) @(posedge clock);
        #1;
        checkOutput("leftover_requests", exp_req.size(), 0);
        checkOutput("leftover_runs", exp_sum.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
